cp0_excctl: RTL
===============

CP0_EXCCTL -- requirements
Module: cp0_excctl

Interface
REQ-001 Parameters SHALL be:
- NUM_INT, 6, number of hardware interrupt lines, legal 1..6.
- TIMER_EN, 1, enables the Count/Compare timer.
- PRID, 32'h0000_4D50, constant PRId value.
- EXC_VECTOR, 32'h0000_4180, handler entry address.

REQ-002 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- addr  in  5  CP0 register number for mfc0/mtc0
- wdata  in  32  mtc0 write data
- we  in  1  mtc0 write strobe
- rdata  out  32  mfc0 read data
- pc  in  32  byte PC of the instruction at the exception point
- in_bd  in  1  that instruction is in a branch delay slot
- exc_req  in  1  synchronous exception request from the pipeline
- exc_code  in  5  cause code of exc_req
- badvaddr  in  32  faulting address, valid with exc_code 4/5
- hw_int  in  NUM_INT  level interrupt lines
- eret  in  1  eret retiring
- exc_take  out  1  flush and redirect this cycle
- handler_pc  out  32  equals EXC_VECTOR
- epc  out  32  current EPC register
- timer_irq  out  1  Cause.TI

Function
REQ-003 Register map SHALL be: 8 BadVAddr (RO), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId (RO); any other addr reads 0.

REQ-004 Status layout SHALL be: IM at [10+NUM_INT-1:10], EXL at [1], IE at [0]; all other bits read 0.

REQ-005 Cause layout SHALL be: BD [31], TI [30], IP [10+NUM_INT-1:10], ExcCode [6:2]; all other bits read 0.

REQ-006 rdata SHALL be combinational from addr and current register state; in a write cycle it returns the pre-write value.

REQ-007 Cause.IP SHALL be refreshed every cycle from hw_int; when TIMER_EN=1, IP[NUM_INT-1] SHALL be hw_int[NUM_INT-1] OR TI.

REQ-008 int_pending SHALL be defined as |(IP & IM) && IE && !EXL, using the registered IP value.

REQ-009 exc_take SHALL be combinational and equal int_pending || exc_req.

REQ-010 Priority: when int_pending and exc_req occur in the same cycle, the interrupt SHALL win and ExcCode SHALL be 0.

REQ-011 On the clock edge of a take:
- EXL <= 1.
- ExcCode <= 0 for an interrupt, else exc_code.
- When EXL was 0 beforehand: EPC <= in_bd ? pc-4 : pc, and BD <= in_bd.
- When EXL was already 1: EPC and BD SHALL be unchanged.

REQ-012 BadVAddr SHALL load badvaddr only on an exception take with exc_code 4 or 5.

REQ-013 eret SHALL clear EXL at the next edge; a take in the same cycle SHALL override eret.

REQ-014 mtc0 writes SHALL be suppressed entirely in any cycle where exc_take=1, because the writing instruction is flushed.

REQ-015 mtc0 field rules:
- EPC writes SHALL force bits [1:0] to 0.
- Writes to Cause SHALL update only ExcCode and BD; IP and TI are not writable.
- Writes to read-only registers SHALL be ignored.

REQ-016 Timer, TIMER_EN=1:
- Count SHALL increment by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
- An mtc0 to Count SHALL load wdata with no increment that cycle.
- TI SHALL be set on the edge at which the incremented Count equals Compare.
- An mtc0 to Compare SHALL clear TI; clear-on-write wins over a simultaneous match.

REQ-017 With TIMER_EN=0, Count, Compare and TI SHALL read 0, and writes to them SHALL be ignored.

REQ-018 handler_pc SHALL equal EXC_VECTOR at all times.

Reset
REQ-019 On reset:
- Status: IM all 1s, IE=1, EXL=0.
- Cause, EPC, BadVAddr, Count and Compare SHALL all be 0.
- exc_take=0 and timer_irq=0 in the cycle after reset, given hw_int=0 and exc_req=0.

REQ-020 Reset SHALL take priority over take, eret, mtc0 and timer update in the same cycle.

Verification
REQ-021 Interrupt: hw_int=6'b000100, pc=32'h3010, in_bd=0 -> IP updates one cycle later, then exc_take=1; the next edge gives EPC=32'h3010, EXL=1, ExcCode=0, Cause[12]=1.

REQ-022 Delay-slot exception: exc_req=1, exc_code=5'd4, pc=32'h3020, in_bd=1, badvaddr=32'h1233 -> EPC=32'h301C, BD=1, BadVAddr=32'h1233, ExcCode=4.

REQ-023 Nested exception: with EXL=1, exc_req=1, exc_code=10 -> exc_take=1, ExcCode=10, EPC unchanged; then eret -> EXL=0.

REQ-024 Simultaneous events:
- hw_int=1 together with exc_req=1, exc_code=12 -> ExcCode=0.
- An mtc0 to EPC in the same cycle is discarded.
- eret in the same cycle still leaves EXL=1.

REQ-025 Timer:
- Write Compare=20 and Count=10 -> TI=1 at the 10th edge after the Count write, then exc_take=1 one cycle later.
- A subsequent Compare write clears TI.
- Count=32'hFFFF_FFFF wraps to 0.

REQ-026 Reset mid-operation: assert reset while EXL=1 and TI=1 -> Status reads 32'h0000_FC01 (NUM_INT=6), Cause=0, EPC=0, exc_take=0.

Source files
------------

// File: rtl/cp0_excctl.sv
// CP0 exception control: Status/Cause/EPC/BadVAddr/Count/Compare/PRId,
// interrupt gating, exception take sequencing, eret and the Count/Compare timer.
module cp0_excctl #(
    parameter int unsigned NUM_INT    = 6,
    parameter bit          TIMER_EN   = 1'b1,
    parameter logic [31:0] PRID       = 32'h0000_4D50,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    output logic [31:0]        rdata,
    input  logic [31:0]        pc,
    input  logic               in_bd,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        badvaddr,
    input  logic [NUM_INT-1:0] hw_int,
    input  logic               eret,
    output logic               exc_take,
    output logic [31:0]        handler_pc,
    output logic [31:0]        epc,
    output logic               timer_irq
);

    localparam int unsigned IP_LO = 10;
    localparam int unsigned IP_HI = IP_LO + NUM_INT - 1;

    typedef enum logic [4:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_STATUS   = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14,
        REG_PRID     = 5'd15
    } cp0_reg_e;

    logic [NUM_INT-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic               bd_q, bd_d;
    logic               ti_q, ti_d;
    logic [NUM_INT-1:0] ip_q, ip_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        badvaddr_q, badvaddr_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;

    logic               int_pending;
    logic               wr_en;
    logic [31:0]        count_inc;
    logic [31:0]        status_rd;
    logic [31:0]        cause_rd;

    // Interrupt gating and take decision from registered state only.
    always_comb begin
        int_pending = (|(ip_q & im_q)) && ie_q && !exl_q;
        exc_take    = int_pending || exc_req;
    end

    // Next-state: take/eret first, then mtc0 (never in a take cycle), then timer.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        count_inc  = count_q + 32'd1;
        wr_en      = we && !exc_take;

        ip_d = hw_int;
        if (TIMER_EN) begin
            ip_d[NUM_INT-1] = hw_int[NUM_INT-1] | ti_q;
        end

        if (exc_take) begin
            exl_d      = 1'b1;
            exc_code_d = int_pending ? 5'd0 : exc_code;
            if (!exl_q) begin
                epc_d = in_bd ? (pc - 32'd4) : pc;
                bd_d  = in_bd;
            end
            if (!int_pending && (exc_code == 5'd4 || exc_code == 5'd5)) begin
                badvaddr_d = badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end

        if (wr_en) begin
            case (addr)
                REG_STATUS: begin
                    im_d  = wdata[IP_HI:IP_LO];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                REG_CAUSE: begin
                    bd_d       = wdata[31];
                    exc_code_d = wdata[6:2];
                end
                REG_EPC: epc_d = {wdata[31:2], 2'b00};
                default: ;
            endcase
        end

        // A Count write replaces the increment and suppresses the match;
        // a Compare write clears TI even if a match happens in the same cycle.
        if (TIMER_EN) begin
            if (wr_en && addr == REG_COUNT) begin
                count_d = wdata;
            end else begin
                count_d = count_inc;
                if (count_inc == compare_q) begin
                    ti_d = 1'b1;
                end
            end
            if (wr_en && addr == REG_COMPARE) begin
                compare_d = wdata;
                ti_d      = 1'b0;
            end
        end else begin
            count_d   = '0;
            compare_d = '0;
            ti_d      = 1'b0;
        end
    end

    // Register update; synchronous reset overrides every other event.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '1;
            exl_q      <= 1'b0;
            ie_q       <= 1'b1;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
        end
    end

    // mfc0 read mux; reflects pre-write state in a write cycle.
    always_comb begin
        status_rd              = '0;
        status_rd[IP_HI:IP_LO] = im_q;
        status_rd[1]           = exl_q;
        status_rd[0]           = ie_q;

        cause_rd               = '0;
        cause_rd[31]           = bd_q;
        cause_rd[30]           = ti_q;
        cause_rd[IP_HI:IP_LO]  = ip_q;
        cause_rd[6:2]          = exc_code_q;

        case (addr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = status_rd;
            REG_CAUSE:    rdata = cause_rd;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID;
            default:      rdata = '0;
        endcase
    end

    assign handler_pc = EXC_VECTOR;
    assign epc        = epc_q;
    assign timer_irq  = ti_q;

endmodule
